// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS-subset control FSM (Moore) with combinational pcen
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;
  state_t r_state, w_next, w_st;
  logic w_pcwrite, w_branch;
  assign state = r_state;
  assign pcen  = w_pcwrite | (w_branch & zero);
  // state register; reset wins over any in-flight instruction
  always_ff @(posedge clk)
    r_state <= reset ? FETCH : w_next;
  // next-state logic; unused encodings and unknown opcodes fall back to FETCH
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE:  w_next = (op == 6'b100011 || op == 6'b101011) ? MEMADR :
                        (op == 6'b000000) ? EXECUTE :
                        (op == 6'b000100) ? BRANCH :
                        (op == 6'b001000) ? ADDIEX :
                        (op == 6'b000010) ? JUMP : FETCH;
      MEMADR:  w_next = (op == 6'b101011) ? MEMWR : MEMRD;
      MEMRD:   w_next = MEMWB;
      EXECUTE: w_next = ALUWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end
  // Moore outputs; during reset selects show FETCH values and all writes are masked
  always_comb begin
    w_st       = reset ? FETCH : r_state;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    case (w_st)
      FETCH: begin
        irwrite    = 1'b1;
        w_pcwrite  = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
      end
      MEMADR, ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = (funct == 6'b100010) ? 3'b110 :
                     (funct == 6'b100100) ? 3'b000 :
                     (funct == 6'b100101) ? 3'b001 :
                     (funct == 6'b101010) ? 3'b111 : 3'b010;
      end
      ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BRANCH: begin
        w_branch   = 1'b1;
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        w_pcwrite = 1'b1;
        pcsrc     = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      irwrite   = 1'b0;
      w_pcwrite = 1'b0;
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed checks of the multicycle control FSM
module tb_mc_controller;
  logic clk = 1'b0, reset, zero;
  logic [5:0] op, funct;
  logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  int total = 0, bad = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
      total++;
      if ({pcen, memwrite, irwrite, regwrite} !== 4'b0000) begin
        bad++; $display("FAIL reset_writes got=%b exp=0000", {pcen, memwrite, irwrite, regwrite});
      end
      total++;
      if ({iord, alusrca, alusrcb, pcsrc, alucontrol} !== 9'b0_0_01_00_010) begin
        bad++; $display("FAIL reset_selects got=%b exp=001000010", {iord, alusrca, alusrcb, pcsrc, alucontrol});
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if ({state, irwrite, pcen} !== 6'b0000_1_1) begin
      bad++; $display("FAIL first_fetch got=%b exp=000011", {state, irwrite, pcen});
    end
  endtask

  task automatic test_lw();
    int seq[6] = '{0, 1, 2, 3, 4, 0};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (state !== 4'(seq[i])) begin bad++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      total++;
      if ({regwrite, memtoreg} !== {2{seq[i] == 4}}) begin
        bad++; $display("FAIL lw_regwrite[%0d] got=%b exp=%b", i, {regwrite, memtoreg}, {2{seq[i] == 4}});
      end
      if (seq[i] == 1) begin
        total++;
        if (alusrcb !== 2'b11) begin bad++; $display("FAIL decode_alusrcb got=%b exp=11", alusrcb); end
      end
      if (seq[i] == 2) begin
        total++;
        if ({alusrca, alusrcb, alucontrol} !== 6'b1_10_010) begin
          bad++; $display("FAIL memadr_sel got=%b exp=110010", {alusrca, alusrcb, alucontrol});
        end
      end
      if (seq[i] == 3) begin
        total++;
        if (iord !== 1'b1) begin bad++; $display("FAIL memrd_iord got=%b exp=1", iord); end
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_sw();
    int seq[5] = '{0, 1, 2, 5, 0};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (state !== 4'(seq[i])) begin bad++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      total++;
      if ({memwrite, iord, regwrite} !== {seq[i] == 5, seq[i] == 5, 1'b0}) begin
        bad++; $display("FAIL sw_enables[%0d] got=%b exp=%b0", i, {memwrite, iord, regwrite}, {2{seq[i] == 5}});
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] f[4] = '{6'b100010, 6'b101010, 6'b100100, 6'b111111};
    logic [2:0] a[4] = '{3'b110, 3'b111, 3'b000, 3'b010};
    op = 6'b000000;
    for (int k = 0; k < 4; k++) begin
      funct = f[k];
      tick();
      tick();
      total++;
      if ({state, alusrca, alusrcb, alucontrol} !== {4'd6, 1'b1, 2'b00, a[k]}) begin
        bad++; $display("FAIL exec[%0d] got=%b exp=%b", k, {state, alusrca, alusrcb, alucontrol}, {4'd6, 3'b100, a[k]});
      end
      tick();
      total++;
      if ({state, regwrite, regdst, memtoreg} !== {4'd7, 3'b110}) begin
        bad++; $display("FAIL aluwb[%0d] got=%b exp=0111110", k, {state, regwrite, regdst, memtoreg});
      end
      tick();
      total++;
      if (state !== 4'd0) begin bad++; $display("FAIL rtype_end[%0d] got=%0d exp=0", k, state); end
    end
  endtask

  task automatic test_addi();
    op = 6'b001000;
    tick();
    tick();
    total++;
    if ({state, alusrca, alusrcb, regwrite} !== {4'd9, 4'b1100}) begin
      bad++; $display("FAIL addiex got=%b exp=10011100", {state, alusrca, alusrcb, regwrite});
    end
    tick();
    total++;
    if ({state, regwrite, regdst, memtoreg} !== {4'd10, 3'b100}) begin
      bad++; $display("FAIL addiwb got=%b exp=1010100", {state, regwrite, regdst, memtoreg});
    end
    tick();
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL addi_end got=%0d exp=0", state); end
  endtask

  task automatic test_branch_jump();
    logic z[2] = '{1'b1, 1'b0};
    op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = z[k];
      tick();
      tick();
      total++;
      if ({state, pcen, pcsrc, alucontrol} !== {4'd8, z[k], 2'b01, 3'b110}) begin
        bad++; $display("FAIL beq[%0d] got=%b exp=%b", k, {state, pcen, pcsrc, alucontrol}, {4'd8, z[k], 5'b01110});
      end
      tick();
      total++;
      if (state !== 4'd0) begin bad++; $display("FAIL beq_end[%0d] got=%0d exp=0", k, state); end
    end
    zero = 1'b0;
    op = 6'b000010;
    tick();
    tick();
    total++;
    if ({state, pcen, pcsrc, irwrite} !== {4'd11, 1'b1, 2'b10, 1'b0}) begin
      bad++; $display("FAIL jump got=%b exp=10111100", {state, pcen, pcsrc, irwrite});
    end
    tick();
    total++;
    if (state !== 4'd0) begin bad++; $display("FAIL jump_end got=%0d exp=0", state); end
  endtask

  task automatic test_mid_reset();
    op = 6'b100011;
    tick();
    tick();
    tick();
    total++;
    if (state !== 4'd3) begin bad++; $display("FAIL midrst_pre got=%0d exp=3", state); end
    reset = 1'b1;
    #1;
    total++;
    if ({regwrite, irwrite, pcen} !== 3'b000) begin
      bad++; $display("FAIL midrst_hold got=%b exp=000", {regwrite, irwrite, pcen});
    end
    tick();
    total++;
    if ({state, regwrite} !== 5'b0000_0) begin
      bad++; $display("FAIL midrst_state got=%b exp=00000", {state, regwrite});
    end
    reset = 1'b0;
    #1;
    total++;
    if ({irwrite, pcen, regwrite} !== 3'b110) begin
      bad++; $display("FAIL midrst_fetch got=%b exp=110", {irwrite, pcen, regwrite});
    end
  endtask

  task automatic test_illegal();
    int seq[3] = '{0, 1, 0};
    op = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (state !== 4'(seq[i])) begin bad++; $display("FAIL ill_state[%0d] got=%0d exp=%0d", i, state, seq[i]); end
      if (seq[i] == 1) begin
        total++;
        if ({pcen, memwrite, irwrite, regwrite} !== 4'b0000) begin
          bad++; $display("FAIL ill_writes got=%b exp=0000", {pcen, memwrite, irwrite, regwrite});
        end
      end
      if (i < 2) tick();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_addi();
    test_branch_jump();
    test_mid_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
